uart_rx_param: RTL and testbench

Parametrised next-generation UART receiver for the peripherals bus. It supports configurable data width, stop bits and oversampling, a runtime baud divisor, runtime parity, and 3-sample majority voting with false-start rejection. Received words go into a holding register with a valid/ack handshake, and parity, framing and overrun flags travel with each word. It sits between the synchronised serial pin and the CPU-side peripheral register interface.

---
 rtl/uart_rx_param.sv | 269 ++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with 3-sample majority voting,
// false-start rejection, runtime baud divisor and parity, and a valid/ack
// holding register that carries parity, framing and overrun flags.
//
// Optional build macro: UART_RX_BREAK_EN
//   defined   - an all-zero frame is reported as a one-cycle break_det pulse
//               instead of a word; the FSM holds in BREAK until the line has
//               been high for one full bit time.
//   undefined - break_det is tied low; an all-zero frame is delivered as
//               dout=0 with frame_err=1.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   din                 asynchronous serial input, idle high
//   baud_div            tick period = baud_div+1 clk cycles
//   parity_en/odd       parity bit present / odd (1) or even (0) parity
//   ack                 consumer took dout; clears valid and overrun
//   dout                received word
//   valid               dout holds an unread word
//   busy                frame reception in progress
//   parity_err          parity mismatch on the word in dout
//   frame_err           a stop bit voted 0 on the word in dout
//   overrun             an unread word was overwritten; sticky until ack
//   break_det           break condition pulse
module uart_rx_param #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 din,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 ack,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    output logic                 busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BCNT_W = $clog2(DATA_BITS + 1);
    localparam int unsigned HALF   = OVERSAMPLE / 2;

    localparam logic [SCNT_W-1:0] S_LO   = SCNT_W'(HALF - 1);
    localparam logic [SCNT_W-1:0] S_MID  = SCNT_W'(HALF);
    localparam logic [SCNT_W-1:0] S_HI   = SCNT_W'(HALF + 1);
    localparam logic [SCNT_W-1:0] S_LAST = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [BCNT_W-1:0] B_DLAST = BCNT_W'(DATA_BITS - 1);
    localparam logic [BCNT_W-1:0] B_SLAST = BCNT_W'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_RX_BREAK_EN
    localparam logic [2:0] ST_BREAK  = 3'd5;
`endif

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rxs_d;
    logic [DIV_WIDTH-1:0] r_tcnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic [SCNT_W-1:0]    r_scnt;
    logic [BCNT_W-1:0]    r_bcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_s0;
    logic                 r_s1;
    logic                 r_perr;
    logic                 r_ferr;
    logic [2:0]           r_state;
    logic [2:0]           w_state_nx;
    logic                 w_done;
`ifdef UART_RX_BREAK_EN
    logic                 r_zero;
    logic                 r_brk_det;
    logic                 w_brk;
`endif

    logic w_rxs;
    logic w_edge;
    logic w_start_edge;
    logic w_tick;
    logic w_vote_tick;
    logic w_wrap;
    logic w_vote;

    assign w_rxs        = r_sync2;
    assign w_edge       = r_rxs_d & ~w_rxs;
    assign w_start_edge = (r_state == ST_IDLE) & w_edge;
    assign w_tick       = (r_tcnt == r_div);
    assign w_vote_tick  = w_tick & (r_scnt == S_HI);
    assign w_wrap       = w_tick & (r_scnt == S_LAST);
    // 2-of-3 majority over the samples at H-1, H and the live one at H+1
    assign w_vote       = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign busy         = (r_state != ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and completion strobes
    always_comb begin
        w_state_nx = r_state;
        w_done     = 1'b0;
`ifdef UART_RX_BREAK_EN
        w_brk      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_edge) w_state_nx = ST_START;
            end
            ST_START: begin
                if (w_vote_tick && w_vote) w_state_nx = ST_IDLE;
                else if (w_wrap)           w_state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (w_wrap && (r_bcnt == B_DLAST))
                    w_state_nx = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_wrap) w_state_nx = ST_STOP;
            end
            ST_STOP: begin
                // Finish on the last stop vote, not at the end of the bit
                if (w_vote_tick && (r_bcnt == B_SLAST)) begin
`ifdef UART_RX_BREAK_EN
                    if (r_zero && !w_vote) begin
                        w_brk      = 1'b1;
                        w_state_nx = ST_BREAK;
                    end else begin
                        w_done     = 1'b1;
                        w_state_nx = ST_IDLE;
                    end
`else
                    w_done     = 1'b1;
                    w_state_nx = ST_IDLE;
`endif
                end
            end
`ifdef UART_RX_BREAK_EN
            ST_BREAK: begin
                if (w_tick && w_rxs && (r_scnt == S_LAST)) w_state_nx = ST_IDLE;
            end
`endif
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Synchroniser, tick/sample counters and frame datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rxs_d   <= 1'b1;
            r_tcnt    <= '0;
            r_div     <= '0;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_scnt    <= '0;
            r_bcnt    <= '0;
            r_shift   <= '0;
            r_s0      <= 1'b0;
            r_s1      <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_BREAK_EN
            r_zero    <= 1'b0;
`endif
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_rxs_d <= r_sync2;

            if (w_start_edge || w_tick) r_tcnt <= '0;
            else                        r_tcnt <= r_tcnt + DIV_WIDTH'(1);

            if (w_start_edge) begin
                r_scnt <= '0;
`ifdef UART_RX_BREAK_EN
            end else if (w_brk || ((r_state == ST_BREAK) && !w_rxs)) begin
                // BREAK reuses scnt to time one full high bit
                r_scnt <= '0;
`endif
            end else if (w_tick) begin
                r_scnt <= (r_scnt == S_LAST) ? '0 : r_scnt + SCNT_W'(1);
            end

            if (w_tick && (r_scnt == S_LO))  r_s0 <= w_rxs;
            if (w_tick && (r_scnt == S_MID)) r_s1 <= w_rxs;

            if (w_start_edge) begin
                r_div     <= baud_div;
                r_par_en  <= parity_en;
                r_par_odd <= parity_odd;
                r_bcnt    <= '0;
                r_perr    <= 1'b0;
                r_ferr    <= 1'b0;
`ifdef UART_RX_BREAK_EN
                r_zero    <= 1'b1;
`endif
            end else begin
                if (w_wrap && (r_state == ST_DATA))
                    r_bcnt <= (r_bcnt == B_DLAST) ? '0 : r_bcnt + BCNT_W'(1);
                else if (w_wrap && (r_state == ST_STOP))
                    r_bcnt <= r_bcnt + BCNT_W'(1);

                if (w_vote_tick && (r_state == ST_DATA))
                    r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                if (w_vote_tick && (r_state == ST_PARITY))
                    r_perr <= w_vote ^ (^r_shift) ^ r_par_odd;
                if (w_vote_tick && (r_state == ST_STOP) && !w_vote)
                    r_ferr <= 1'b1;
`ifdef UART_RX_BREAK_EN
                if (w_vote_tick && ((r_state == ST_DATA) || (r_state == ST_PARITY) ||
                                    (r_state == ST_STOP)))
                    r_zero <= r_zero & ~w_vote;
`endif
            end
        end
    end

    // Holding register and valid/ack/overrun handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (w_done) begin
            dout       <= r_shift;
            parity_err <= r_perr;
            frame_err  <= r_ferr | ~w_vote;
            valid      <= 1'b1;
            overrun    <= valid & ~ack;
        end else if (ack && valid) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end
    end

`ifdef UART_RX_BREAK_EN
    // One-cycle break indication
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_brk_det <= 1'b0;
        else          r_brk_det <= w_brk;
    end
    assign break_det = r_brk_det;
`else
    assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param (DATA_BITS=8, STOP_BITS=1, OVERSAMPLE=16).
module tb_uart_rx_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        din = 1'b1;
    logic [15:0] baud_div = 16'd0;
    logic        parity_en = 1'b0;
    logic        parity_odd = 1'b0;
    logic        ack = 1'b0;
    logic [7:0]  dout;
    logic        valid, busy, parity_err, frame_err, overrun, break_det;

    always #5 clk = ~clk;

    uart_rx_param #(
        .DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_WIDTH(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .din(din), .baud_div(baud_div),
        .parity_en(parity_en), .parity_odd(parity_odd), .ack(ack),
        .dout(dout), .valid(valid), .busy(busy), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .break_det(break_det)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Edge timestamps of busy/valid and break pulse count
    int   cyc = 0, t_busy_rise = 0, t_busy_fall = 0, t_valid_rise = 0, n_break = 0;
    logic p_busy = 1'b0, p_valid = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (busy && !p_busy)   t_busy_rise  <= cyc;
        if (!busy && p_busy)   t_busy_fall  <= cyc;
        if (valid && !p_valid) t_valid_rise <= cyc;
        if (break_det)         n_break      <= n_break + 1;
        p_busy  <= busy;
        p_valid <= valid;
    end

    // Drives one frame starting at the current negedge; flip inverts din for one cycle
    task automatic send_frame(input logic [7:0] data, input logic pen, input logic pbit,
                              input logic stop, input int bitcyc, input int flip);
        logic [10:0] bits;
        int nb;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = data[i];
        nb = 9;
        if (pen) begin
            bits[nb] = pbit;
            nb++;
        end
        bits[nb] = stop;
        nb++;
        for (int c = 0; c < nb * bitcyc; c++) begin
            din = bits[c / bitcyc] ^ (c == flip);
            @(negedge clk);
        end
        din = 1'b1;
        repeat (2 * bitcyc) @(negedge clk);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        pen;
        logic        podd;
        logic        pbit;
        logic        stop;
        logic [15:0] div;
        logic [7:0]  exp_dout;
        logic        exp_perr;
        logic        exp_ferr;
    } vec_t;

    vec_t vecs[8];
    int   busy_before;

    initial begin
        vecs[0] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 8'hC3, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 16'd0, 8'h07, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0, 8'h07, 1'b0, 1'b0};
        vecs[4] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 16'd0, 8'h07, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'h3C, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3, 8'h81, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_flags", {26'd0, valid, busy, parity_err, frame_err, overrun, break_det}, 32'h0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5: latency from busy rise to valid, busy falls with completion
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 16, -1);
        check("a5_dout", 32'(dout), 32'hA5);
        check("a5_valid", 32'(valid), 32'h1);
        check("a5_flags", {29'd0, parity_err, frame_err, overrun}, 32'h0);
        check("a5_latency", 32'(t_valid_rise - t_busy_rise), 32'd154);
        check("a5_busy_fall", 32'(t_busy_fall - t_busy_rise), 32'd154);
        pulse_ack();
        check("a5_ack_valid", 32'(valid), 32'h0);
        check("a5_ack_dout_hold", 32'(dout), 32'hA5);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            baud_div   = vecs[i].div;
            parity_en  = vecs[i].pen;
            parity_odd = vecs[i].podd;
            send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].stop,
                       16 * (int'(vecs[i].div) + 1), -1);
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'h1);
            check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d_perr", i), 32'(parity_err), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d_ferr", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_ovr", i), 32'(overrun), 32'h0);
            pulse_ack();
        end
        baud_div = 16'd0;
        parity_en = 1'b0;
        parity_odd = 1'b0;

        // One-cycle low glitch: false start rejected
        busy_before = t_busy_rise;
        din = 1'b0;
        @(negedge clk);
        din = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_busy_pulse", 32'(t_busy_rise != busy_before), 32'h1);
        check("glitch_busy_end", 32'(busy), 32'h0);
        check("glitch_valid", 32'(valid), 32'h0);

        // Single-sample flip at scnt=H of data bit 3 is outvoted
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, 16, 73);
        check("vote_dout", 32'(dout), 32'h00);
        check("vote_ferr", 32'(frame_err), 32'h0);
        pulse_ack();

        // Overrun: 0x11 then 0x22 without ack
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 16, -1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 16, -1);
        check("ovr_dout", 32'(dout), 32'h22);
        check("ovr_set", 32'(overrun), 32'h1);
        pulse_ack();
        check("ovr_ack_valid", 32'(valid), 32'h0);
        check("ovr_ack_clear", 32'(overrun), 32'h0);

        // ack in the completion cycle of 0x33 while 0x44 is unread
        send_frame(8'h44, 1'b0, 1'b0, 1'b1, 16, -1);
        fork
            send_frame(8'h33, 1'b0, 1'b0, 1'b1, 16, -1);
            begin
                repeat (156) @(negedge clk);
                check("same_pre_dout", 32'(dout), 32'h44);
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
                check("same_dout", 32'(dout), 32'h33);
                check("same_valid", 32'(valid), 32'h1);
                check("same_ovr", 32'(overrun), 32'h0);
            end
        join

        // Reset mid data bit with an unread word held
        check("pre_rst_valid", 32'(valid), 32'h1);
        fork
            send_frame(8'h99, 1'b0, 1'b0, 1'b1, 16, -1);
            begin
                repeat (50) @(negedge clk);
                reset_n = 1'b0;
                #1;
                check("mid_rst_dout", 32'(dout), 32'h0);
                check("mid_rst_flags",
                      {26'd0, valid, busy, parity_err, frame_err, overrun, break_det}, 32'h0);
            end
        join
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 16, -1);
        check("post_rst_valid", 32'(valid), 32'h1);
        check("post_rst_dout", 32'(dout), 32'h5A);
        pulse_ack();

        // Line held low for 12 bit times, then released
        din = 1'b0;
        repeat (192) @(negedge clk);
        din = 1'b1;
`ifdef UART_RX_BREAK_EN
        repeat (10) @(negedge clk);
        check("brk_busy_hold", 32'(busy), 32'h1);
        repeat (10) @(negedge clk);
        check("brk_busy_end", 32'(busy), 32'h0);
        check("brk_pulses", 32'(n_break), 32'h1);
        check("brk_valid", 32'(valid), 32'h0);
`else
        repeat (20) @(negedge clk);
        check("zero_valid", 32'(valid), 32'h1);
        check("zero_dout", 32'(dout), 32'h0);
        check("zero_ferr", 32'(frame_err), 32'h1);
        check("zero_perr", 32'(parity_err), 32'h0);
        check("zero_no_brk", 32'(n_break), 32'h0);
        check("zero_busy", 32'(busy), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
